shift_job_scheduler: RTL

Arbitrated sequencer that shares one internal WIDTH-bit shift datapath between two requesters. Each requester submits a word, a shift amount and a direction. The block grants one job at a time using round-robin priority, shifts the word one position per cycle for the requested count, and returns the result with a one-cycle done pulse. It sits between client logic and the shift-register datapath, replacing per-client load/shift sequencing.

---
 rtl/shift_job_scheduler_if.sv | 33 +++
 rtl/shift_job_scheduler.sv | 111 +++++++++++
 2 files changed

// File: rtl/shift_job_scheduler_if.sv
// Job-submission bus between two requesters and shift_job_scheduler.
// Per-requester signals: req/data/amt/dir in, gnt out.
// Shared status signals: busy, done, done_id, result.
// The master modport is the client side. The slave modport is the scheduler side.
interface shift_job_scheduler_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(WIDTH)
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic [AW-1:0]    amt0;
  logic             dir0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic [AW-1:0]    amt1;
  logic             dir1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] result;

  modport master (
    output req0, data0, amt0, dir0, req1, data1, amt1, dir1,
    input  gnt0, gnt1, busy, done, done_id, result
  );

  modport slave (
    input  req0, data0, amt0, dir0, req1, data1, amt1, dir1,
    output gnt0, gnt1, busy, done, done_id, result
  );
endinterface

// File: rtl/shift_job_scheduler.sv
// Round-robin scheduler that shares one WIDTH-bit logical shifter between two requesters.
// A granted word is shifted by one position per cycle for its requested count.
// The result is then presented together with a one-cycle done pulse.
// Ports:
//   clk  - clock; all state updates on the rising edge
//   rst  - asynchronous, active-low reset
//   bus  - slave side of shift_job_scheduler_if:
//            req/data/amt/dir per requester (inputs)
//            gnt0/gnt1, busy, done, done_id, result (outputs)
// Every output is a flop or is decoded from the state register.
module shift_job_scheduler #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(WIDTH)
) (
  input logic                  clk,
  input logic                  rst,
  shift_job_scheduler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             id_q, id_d;
  // Pointer: 0 favours requester 0 under contention, 1 favours requester 1.
  logic             prio_q, prio_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;

  logic             pick1;
  logic [WIDTH-1:0] sel_data;
  logic [AW-1:0]    sel_amt;
  logic             sel_dir;

  // Requester 1 wins when it is the only requester, or when both request and the pointer favours it.
  assign pick1    = bus.req1 & (~bus.req0 | prio_q);
  assign sel_data = pick1 ? bus.data1 : bus.data0;
  assign sel_amt  = pick1 ? bus.amt1  : bus.amt0;
  assign sel_dir  = pick1 ? bus.dir1  : bus.dir0;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    id_d    = id_q;
    prio_d  = prio_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req0 | bus.req1) begin
          shift_d = sel_data;
          cnt_d   = sel_amt;
          dir_d   = sel_dir;
          id_d    = pick1;
          prio_d  = ~pick1;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          state_d = (sel_amt != '0) ? StShift : StDone;
        end
      end
      StShift: begin
        shift_d = dir_q ? {1'b0, shift_q[WIDTH-1:1]} : {shift_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);
  assign bus.done_id = id_q;
  // The shift register holds the result after DONE until the next job is loaded.
  assign bus.result  = shift_q;

endmodule
